// File: rtl/wptr_pkg.sv
// Shared limits and Gray-code helpers for the FIFO write-pointer controller.
// Helpers work at the maximum width; callers zero-extend and truncate.
package wptr_pkg;

    localparam int PTR_WIDTH_MIN = 2;
    localparam int PTR_WIDTH_MAX = 12;
    localparam int GW            = PTR_WIDTH_MAX + 1;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] r;
        r[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/wptr_gray2bin.sv
// Combinational Gray-to-binary converter for the synchronised read pointer.
module wptr_gray2bin
    import wptr_pkg::*;
#(
    parameter int W = 7
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    assign o_bin = W'(gray2bin(GW'(i_gray)));

endmodule

// File: rtl/wptr_ctrl.sv
// Async-FIFO write-side pointer, full/almost-full and fill-level logic.
// Optional sticky overflow flag enabled by defining WPTR_OVF_EN.
module wptr_ctrl
    import wptr_pkg::*;
#(
    parameter int PTR_WIDTH = 6,
    parameter int AFULL_DEF = (1 << PTR_WIDTH) - 2
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 w_en,
    input  logic [PTR_WIDTH:0]   g_rptr_sync,
    input  logic [PTR_WIDTH:0]   afull_thresh,
`ifdef WPTR_OVF_EN
    input  logic                 ovf_clr,
    output logic                 ovf,
`endif
    output logic                 w_ack,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wcount
);

    localparam int P = PTR_WIDTH;
    localparam int W = PTR_WIDTH + 1;
    localparam logic [P:0] DEPTH = {1'b1, {P{1'b0}}};
    localparam logic [P:0] AFULL_C = AFULL_DEF[P:0];

    logic [P:0] r_bwptr;
    logic [P:0] r_gwptr;
    logic [P:0] r_wcount;
    logic       r_full;
    logic       r_afull;

    logic [P:0] w_brptr;
    logic [P:0] w_bnext;
    logic [P:0] w_gnext;
    logic [P:0] w_diff;
    logic [P:0] w_thr;
    logic       w_full_nx;
    logic       w_afull_nx;

    wptr_gray2bin #(.W(W)) u_g2b (
        .i_gray (g_rptr_sync),
        .o_bin  (w_brptr)
    );

    // Reset also blocks acceptance, since full reads 0 while held in reset.
    assign w_ack   = w_en & ~r_full & ~wrst;
    assign w_bnext = r_bwptr + {{P{1'b0}}, w_ack};
    assign w_gnext = W'(bin2gray(GW'(w_bnext)));
    assign w_diff  = w_bnext - w_brptr;
    assign w_thr   = (afull_thresh == '0) ? AFULL_C : afull_thresh;

    assign w_full_nx = (w_gnext == {~g_rptr_sync[P:P-1],
                                    g_rptr_sync[P-2:0]});

    assign w_afull_nx = (w_thr > DEPTH) ? w_full_nx
                                        : (w_diff >= w_thr);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_bwptr  <= '0;
            r_gwptr  <= '0;
            r_wcount <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
        end else begin
            r_bwptr  <= w_bnext;
            r_gwptr  <= w_gnext;
            r_wcount <= w_diff;
            r_full   <= w_full_nx;
            r_afull  <= w_afull_nx;
        end
    end

`ifdef WPTR_OVF_EN
    logic r_ovf;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_ovf <= 1'b0;
        end else if (w_en & r_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

    assign waddr       = r_bwptr[P-1:0];
    assign b_wptr      = r_bwptr;
    assign g_wptr      = r_gwptr;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign wcount      = r_wcount;

endmodule

// File: tb/tb_wptr_ctrl.sv
// Self-checking bench for wptr_ctrl at PTR_WIDTH=3 (depth 8).
// Reference model tracks total words written/read as plain integers.
module tb_wptr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       w_en;
    logic [3:0] g_rptr_sync;
    logic [3:0] afull_thresh;
    logic       ovf_clr;
    logic       w_ack;
    logic [2:0] waddr;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wcount;
`ifdef WPTR_OVF_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    int   wr_cnt, rd_cnt, m_thr;
    logic m_full, m_af, m_ovf;
    logic ack_obs, ack_exp;

    wptr_ctrl #(.PTR_WIDTH(3)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .w_en         (w_en),
        .g_rptr_sync  (g_rptr_sync),
        .afull_thresh (afull_thresh),
`ifdef WPTR_OVF_EN
        .ovf_clr      (ovf_clr),
        .ovf          (ovf),
`endif
        .w_ack        (w_ack),
        .waddr        (waddr),
        .b_wptr       (b_wptr),
        .g_wptr       (g_wptr),
        .full         (full),
        .almost_full  (almost_full),
        .wcount       (wcount)
    );

    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray4(input int n);
        int m;
        m = n % 16;
        return 4'(m ^ (m >> 1));
    endfunction

    task automatic m_reset();
        wr_cnt = 0;
        rd_cnt = 0;
        m_full = 1'b0;
        m_af   = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge wclk);
        #1;
        w_en        = 1'b0;
        ovf_clr     = 1'b0;
        g_rptr_sync = 4'd0;
        wrst        = 1'b1;
        #3;
        wrst = 1'b0;
        m_reset();
    endtask

    // One wclk cycle: drive, sample w_ack, clock, update model.
    task automatic step(input logic we, input int rd_new,
                        input logic clr);
        int eff, fill;
        w_en        = we;
        g_rptr_sync = gray4(rd_new);
        ovf_clr     = clr;
        #1;
        ack_exp = we && !m_full;
        ack_obs = w_ack;
        @(posedge wclk);
        if (we && m_full)
            m_ovf = 1'b1;
        else if (clr)
            m_ovf = 1'b0;
        if (ack_exp)
            wr_cnt++;
        rd_cnt = rd_new;
        fill   = wr_cnt - rd_cnt;
        eff    = (m_thr == 0) ? 6 : m_thr;
        m_full = (fill == 8);
        m_af   = (eff > 8) ? m_full : (fill >= eff);
        #1;
        w_en    = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({b_wptr, g_wptr, wcount} !== 12'd0) begin
            bad++;
            $display("FAIL reset_ptrs got b=%h g=%h c=%h want 0",
                     b_wptr, g_wptr, wcount);
        end
        total++;
        if ({full, almost_full} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags got %b want 00",
                     {full, almost_full});
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 0, 1'b0);
            total++;
            if (ack_obs !== 1'b1 || wcount !== 4'(i)) begin
                bad++;
                $display("FAIL fill_cnt i=%0d got ack=%b c=%0d want 1 %0d",
                         i, ack_obs, wcount, i);
            end
            total++;
            if (almost_full !== (i >= 6) || full !== (i == 8)) begin
                bad++;
                $display("FAIL fill_flags i=%0d got af=%b f=%b",
                         i, almost_full, full);
            end
        end
        total++;
        if (g_wptr !== 4'b1100 || waddr !== 3'd0) begin
            bad++;
            $display("FAIL fill_gray got %b/%0d want 1100/0",
                     g_wptr, waddr);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 0, 1'b0);
            total++;
            if (ack_obs !== 1'b0 || b_wptr !== 4'd8) begin
                bad++;
                $display("FAIL ovf_hold got ack=%b b=%0d want 0 8",
                         ack_obs, b_wptr);
            end
        end
`ifdef WPTR_OVF_EN
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set got %b want 1", ovf);
        end
        step(1'b1, 0, 1'b1);
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_setwins got %b want 1", ovf);
        end
        step(1'b0, 0, 1'b1);
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clr got %b want 0", ovf);
        end
`endif
    endtask

    task automatic test_free();
        step(1'b0, 1, 1'b0);
        total++;
        if (full !== 1'b0 || wcount !== 4'd7) begin
            bad++;
            $display("FAIL free got f=%b c=%0d want 0 7", full, wcount);
        end
        step(1'b1, 1, 1'b0);
        total++;
        if (ack_obs !== 1'b1 || b_wptr !== 4'd9 || full !== 1'b1) begin
            bad++;
            $display("FAIL free_wr got ack=%b b=%0d f=%b want 1 9 1",
                     ack_obs, b_wptr, full);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        do_reset();
        prev = g_wptr;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, i, 1'b0);
            total++;
            if (ack_obs !== 1'b1 || full !== 1'b0 ||
                wcount !== 4'd1 || b_wptr !== 4'((i + 1) % 16)) begin
                bad++;
                $display("FAIL wrap i=%0d got ack=%b f=%b c=%0d b=%0d",
                         i, ack_obs, full, wcount, b_wptr);
            end
            total++;
            if ($countones(prev ^ g_wptr) != 1) begin
                bad++;
                $display("FAIL wrap_gray i=%0d got %b->%b want 1 bit",
                         i, prev, g_wptr);
            end
            prev = g_wptr;
        end
    endtask

    task automatic test_thresh();
        do_reset();
        afull_thresh = 4'd3;
        m_thr = 3;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 0, 1'b0);
            total++;
            if (almost_full !== (i >= 3)) begin
                bad++;
                $display("FAIL thr3 i=%0d got %b want %b",
                         i, almost_full, i >= 3);
            end
        end
        do_reset();
        afull_thresh = 4'd9;
        m_thr = 9;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 0, 1'b0);
            total++;
            if (almost_full !== (i == 8) || full !== (i == 8)) begin
                bad++;
                $display("FAIL thr9 i=%0d got af=%b f=%b", i,
                         almost_full, full);
            end
        end
        afull_thresh = 4'd0;
        m_thr = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1'b1, 0, 1'b0);
        w_en = 1'b1;
        wrst = 1'b1;
        #1;
        total++;
        if ({b_wptr, g_wptr, wcount, full, almost_full, w_ack}
            !== 15'd0) begin
            bad++;
            $display("FAIL rst_async got b=%0d c=%0d f=%b ack=%b",
                     b_wptr, wcount, full, w_ack);
        end
        @(posedge wclk);
        #1;
        total++;
        if (b_wptr !== 4'd0 || w_ack !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold got b=%0d ack=%b want 0 0",
                     b_wptr, w_ack);
        end
        wrst = 1'b0;
        w_en = 1'b0;
        m_reset();
        step(1'b1, 0, 1'b0);
        total++;
        if (ack_obs !== 1'b1 || b_wptr !== 4'd1) begin
            bad++;
            $display("FAIL rst_first got ack=%b b=%0d want 1 1",
                     ack_obs, b_wptr);
        end
    endtask

    task automatic test_random();
        int thr_tab [7] = '{0, 1, 3, 5, 8, 9, 15};
        int rd_new;
        logic we;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                m_thr = thr_tab[$urandom_range(0, 6)];
                afull_thresh = 4'(m_thr);
            end
            we = ($urandom_range(0, 2) != 0);
            rd_new = rd_cnt;
            if (rd_cnt < wr_cnt && $urandom_range(0, 2) == 0)
                rd_new = rd_cnt + 1;
            step(we, rd_new, 1'b0);
            total++;
            if (ack_obs !== ack_exp ||
                b_wptr !== 4'(wr_cnt % 16) ||
                g_wptr !== gray4(wr_cnt) ||
                waddr !== 3'(wr_cnt % 8)) begin
                bad++;
                $display("FAIL rnd_ptr i=%0d got ack=%b b=%0d want %b %0d",
                         i, ack_obs, b_wptr, ack_exp, wr_cnt % 16);
            end
            total++;
            if (wcount !== 4'(wr_cnt - rd_cnt) || full !== m_full ||
                almost_full !== m_af) begin
                bad++;
                $display("FAIL rnd_flag i=%0d got c=%0d f=%b af=%b want %0d %b %b",
                         i, wcount, full, almost_full,
                         wr_cnt - rd_cnt, m_full, m_af);
            end
        end
        afull_thresh = 4'd0;
        m_thr = 0;
    endtask

    initial begin
        wrst         = 1'b1;
        w_en         = 1'b0;
        ovf_clr      = 1'b0;
        g_rptr_sync  = 4'd0;
        afull_thresh = 4'd0;
        m_thr        = 0;
        m_reset();
        repeat (2) @(posedge wclk);
        #1;
        test_reset();
        wrst = 1'b0;
        test_fill();
        test_overflow();
        test_free();
        test_wrap();
        test_thresh();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
